piso_serializer: RTL and testbench

Parametrised parallel-in/serial-out serializer with valid/ready load handshake, programmable bit period and selectable bit order. Accepts a WIDTH-bit word and drives it out one bit per bit period on a registered serial line, with framing strobes for downstream line logic (UART/SPI-style transmit paths). It supersedes the fixed 4-bit shift-on-every-clock PISO. It adds flow control, a clock-divided bit rate, and optional gapless back-to-back frames.

---
 rtl/piso_serializer.sv | 124 ++++++++++++
 tb/tb_piso_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: WIDTH-bit parallel-in/serial-out shifter with valid/ready load, DIV-cycle bit period and selectable bit order
// Ports: clk, reset_n (async active-low); load_valid/load_ready/d load handshake; q/q_valid serial
// output; frame_start/frame_done one-cycle framing strobes; busy while a frame is shifting.
// Define PISO_SERIALIZER_DBUF_EN to add a one-word hold buffer for gapless back-to-back frames.
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV = 1,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d,
  output logic             q,
  output logic             q_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_adv;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic ready_q, q_q, valid_q, start_q, done_q;
  logic accept, bit_end, last, head_d;
`ifdef PISO_SERIALIZER_DBUF_EN
  logic [WIDTH-1:0] hold_q, hold_d;
  logic hold_full_q, hold_full_d;
`endif
  assign accept  = load_valid && ready_q;
  assign bit_end = (state_q == SHIFT) && (div_q == DIV_LAST);
  assign last    = bit_end && (bit_q == BIT_LAST);
  assign sr_adv  = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
  assign head_d  = LSB_FIRST ? sr_d[0] : sr_d[WIDTH-1];
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    bit_d = bit_q;
    div_d = div_q;
`ifdef PISO_SERIALIZER_DBUF_EN
    hold_d = hold_q;
    hold_full_d = hold_full_q;
`endif
    if (state_q == IDLE) begin
      if (accept) begin
        state_d = SHIFT;
        sr_d = d;
        bit_d = '0;
        div_d = '0;
      end
    end else begin
      div_d = bit_end ? '0 : div_q + 1'b1;
      bit_d = bit_end ? (last ? '0 : bit_q + 1'b1) : bit_q;
      sr_d = bit_end ? sr_adv : sr_q;
      if (last) begin
`ifdef PISO_SERIALIZER_DBUF_EN
        // A buffered word, or one accepted right at frame end, starts the next frame with no gap.
        if (hold_full_q) begin
          sr_d = hold_q;
          hold_full_d = 1'b0;
        end else if (accept) begin
          sr_d = d;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
`ifdef PISO_SERIALIZER_DBUF_EN
      else if (accept) begin
        hold_d = d;
        hold_full_d = 1'b1;
      end
`endif
    end
  end
  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q <= '0;
      bit_q <= '0;
      div_q <= '0;
      ready_q <= 1'b0;
      q_q <= 1'b0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      done_q <= 1'b0;
`ifdef PISO_SERIALIZER_DBUF_EN
      hold_q <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      bit_q <= bit_d;
      div_q <= div_d;
      q_q <= (state_d == SHIFT) && head_d;
      valid_q <= state_d == SHIFT;
      start_q <= (state_d == SHIFT) && (bit_d == '0) && (div_d == '0);
      done_q <= (state_d == SHIFT) && (bit_d == BIT_LAST) && (div_d == DIV_LAST);
`ifdef PISO_SERIALIZER_DBUF_EN
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q <= !hold_full_d;
`else
      ready_q <= state_d == IDLE;
`endif
    end
  end
  assign load_ready  = ready_q;
  assign q           = q_q;
  assign q_valid     = valid_q;
  assign frame_start = start_q;
  assign frame_done  = done_q;
  assign busy        = valid_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: checks piso_serializer (MSB-first DIV=1 and LSB-first DIV=3 instances) against a frame-level model
module tb_piso_serializer;
`ifdef PISO_SERIALIZER_DBUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  typedef struct {
    bit busy;
    bit ready;
    logic [7:0] word;
    int t;
    bit hf;
    logic [7:0] hold;
  } mdl_t;
  typedef struct {
    bit lv;
    logic [7:0] d;
    logic [5:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic lv0 = 1'b0, lv1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic rdy0, q0, qv0, fs0, fd0, bsy0, rdy1, q1, qv1, fs1, fd1, bsy1;
  logic [5:0] o0, o1;
  int checks = 0;
  int failures = 0;
  mdl_t m0, m1;
  vec_t tv[10];
  bit lsb_seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  bit f0_seq[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  bit c3_seq[8] = '{0, 0, 1, 1, 1, 1, 0, 0};
  bit gl_seq[16] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
  always #5 clk = ~clk;
  piso_serializer #(.WIDTH(8), .DIV(1), .LSB_FIRST(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .load_valid(lv0), .load_ready(rdy0), .d(d0),
    .q(q0), .q_valid(qv0), .frame_start(fs0), .frame_done(fd0), .busy(bsy0)
  );
  piso_serializer #(.WIDTH(8), .DIV(3), .LSB_FIRST(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .load_valid(lv1), .load_ready(rdy1), .d(d1),
    .q(q1), .q_valid(qv1), .frame_start(fs1), .frame_done(fd1), .busy(bsy1)
  );
  assign o0 = {rdy0, q0, qv0, fs0, fd0, bsy0};
  assign o1 = {rdy1, q1, qv1, fs1, fd1, bsy1};
  // Expected {ready, q, q_valid, frame_start, frame_done, busy} from the frame position t.
  function automatic logic [5:0] mexp(mdl_t m, int dv, bit lsb);
    int bi;
    bi = m.t / dv;
    if (!m.busy) return {m.ready, 5'b00000};
    return {m.ready, lsb ? m.word[bi] : m.word[7 - bi], 1'b1, m.t == 0, m.t == 8 * dv - 1, 1'b1};
  endfunction
  function automatic mdl_t mstep(mdl_t m, int dv, bit lv, logic [7:0] dd);
    bit acc;
    mdl_t n;
    acc = lv && m.ready;
    n = m;
    if (m.busy && m.t < 8 * dv - 1) begin
      n.t = m.t + 1;
      if (acc) begin
        n.hf = 1'b1;
        n.hold = dd;
      end
    end else if (m.busy && m.hf) begin
      n.word = m.hold;
      n.hf = 1'b0;
      n.t = 0;
    end else if (acc) begin
      n.busy = 1'b1;
      n.word = dd;
      n.t = 0;
    end else begin
      n.busy = 1'b0;
    end
    n.ready = DB ? !n.hf : !n.busy;
    return n;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(bit l0, logic [7:0] x0, bit l1, logic [7:0] x1);
    lv0 = l0;
    d0 = x0;
    lv1 = l1;
    d1 = x1;
    chk("model_u0", {26'd0, o0}, {26'd0, mexp(m0, 1, 1'b0)});
    chk("model_u1", {26'd0, o1}, {26'd0, mexp(m1, 3, 1'b1)});
    @(posedge clk);
    m0 = mstep(m0, 1, l0, x0);
    m1 = mstep(m1, 3, l1, x1);
    @(negedge clk);
  endtask
  task automatic idle(int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask
  initial begin
    int nb;
    int nfs;
    tv[0] = '{1'b1, 8'hA5, 6'b100000};
    tv[1] = '{1'b0, 8'h00, {DB, 5'b11101}};
    tv[2] = '{1'b0, 8'h00, {DB, 5'b01001}};
    tv[3] = '{1'b0, 8'h00, {DB, 5'b11001}};
    tv[4] = '{1'b0, 8'h00, {DB, 5'b01001}};
    tv[5] = '{1'b0, 8'h00, {DB, 5'b01001}};
    tv[6] = '{1'b0, 8'h00, {DB, 5'b11001}};
    tv[7] = '{1'b0, 8'h00, {DB, 5'b01001}};
    tv[8] = '{1'b0, 8'h00, {DB, 5'b11011}};
    tv[9] = '{1'b0, 8'h00, 6'b100000};
    m0 = '{default: 0};
    m1 = '{default: 0};
    repeat (2) @(negedge clk);
    chk("reset_u0", {26'd0, o0}, 32'd0);
    chk("reset_u1", {26'd0, o1}, 32'd0);
    reset_n = 1'b1;
    chk("release_ready_low", {31'd0, rdy0}, 32'd0);
    idle(1);
    chk("release_ready_rise", {31'd0, rdy0}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("msb_vec%0d", i), {26'd0, o0}, {26'd0, tv[i].exp});
      step(tv[i].lv, tv[i].d, 1'b0, 8'h00);
    end
    idle(2);
    step(1'b0, 8'h00, 1'b1, 8'hA5);
    nb = 0;
    for (int c = 0; c < 30; c++) begin
      if (bsy1) begin
        if (nb < 24) chk("lsb_div3_q", {31'd0, q1}, {31'd0, lsb_seq[nb / 3]});
        nb++;
      end
      idle(1);
    end
    chk("lsb_busy_cycles", nb, 24);
    idle(2);
    step(1'b1, 8'hFF, 1'b0, 8'h00);
    idle(3);
    #2 reset_n = 1'b0;
    #1;
    chk("midframe_reset_u0", {26'd0, o0}, 32'd0);
    chk("midframe_reset_u1", {26'd0, o1}, 32'd0);
    m0 = '{default: 0};
    m1 = '{default: 0};
    @(negedge clk);
    chk("reset_held_u0", {26'd0, o0}, 32'd0);
    reset_n = 1'b1;
    idle(1);
    chk("post_reset_ready", {31'd0, rdy0}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      chk("post_reset_no_residue", {31'd0, qv0}, 32'd0);
      idle(1);
    end
`ifdef PISO_SERIALIZER_DBUF_EN
    step(1'b1, 8'hF0, 1'b0, 8'h00);
    chk("gapless_ready_first", {31'd0, rdy0}, 32'd1);
    chk("gapless_q0", {31'd0, q0}, 32'd1);
    step(1'b1, 8'h0F, 1'b0, 8'h00);
    for (int c = 1; c < 16; c++) begin
      chk("gapless_qv", {31'd0, qv0}, 32'd1);
      chk("gapless_q", {31'd0, q0}, {31'd0, gl_seq[c]});
      chk("gapless_ready", {31'd0, rdy0}, (c >= 8) ? 32'd1 : 32'd0);
      idle(1);
    end
    chk("gapless_end", {31'd0, qv0}, 32'd0);
`else
    chk("flow_ready_idle", {31'd0, rdy0}, 32'd1);
    step(1'b1, 8'hF0, 1'b0, 8'h00);
    for (int c = 0; c < 8; c++) begin
      chk("flow_ready_low", {31'd0, rdy0}, 32'd0);
      chk("flow_q_first", {31'd0, q0}, {31'd0, f0_seq[c]});
      step(1'b1, 8'h3C, 1'b0, 8'h00);
    end
    chk("flow_gap_idle", {31'd0, qv0}, 32'd0);
    chk("flow_gap_ready", {31'd0, rdy0}, 32'd1);
    step(1'b1, 8'h3C, 1'b0, 8'h00);
    chk("flow_second_start", {31'd0, fs0}, 32'd1);
    for (int c = 0; c < 8; c++) begin
      chk("flow_q_second", {31'd0, q0}, {31'd0, c3_seq[c]});
      idle(1);
    end
`endif
    idle(12);
    nfs = 0;
    step(1'b1, 8'h55, 1'b0, 8'h00);
    nfs += int'(fs0);
    step(DB, 8'hAA, 1'b0, 8'h00);
    nfs += int'(fs0);
    chk("backpressure_ready", {31'd0, rdy0}, 32'd0);
    step(1'b1, 8'h33, 1'b0, 8'h00);
    for (int c = 0; c < 24; c++) begin
      nfs += int'(fs0);
      idle(1);
    end
    chk("backpressure_frames", nfs, DB ? 32'd2 : 32'd1);
    for (int c = 0; c < 400; c++)
      step(($urandom % 3) != 0, 8'($urandom), ($urandom % 3) != 0, 8'($urandom));
    idle(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
